// File: rtl/mem_stage.sv
// Memory stage of the Dioptase pipe: data-memory request/ack handshake with
// byte/half/word sizing, alignment checking and bus timeout, feeding writeback.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  in_op,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [4:0]  in_rd,
  input  logic        in_wb_en,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_misaligned,
  output logic        exc_bus_timeout
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        cap_rd;
  logic [1:0]        cap_size;
  logic              cap_signed;
  logic [1:0]        cap_lane;

  logic              is_mem;
  logic              misaligned;
  logic              issue;
  logic              ack;
  logic              timeout_hit;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic              unused_in;

  // Memory class is carried by the decoded load/store flags, not the raw opcode.
  assign unused_in = ^in_op;

  assign stall_out   = (state == S_WAIT);
  assign is_mem      = in_is_load | in_is_store;
  assign misaligned  = ((in_size == 2'b01) && in_result[0]) ||
                       (in_size[1] && (in_result[1:0] != 2'b00));
  assign issue       = (state == S_IDLE) && in_valid && is_mem && !misaligned;
  assign ack         = (state == S_WAIT) && mem_req && mem_ack;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_WAIT) && !mem_ack &&
                       (cnt == CNT_LAST);

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = in_store_data;
    case (in_size)
      2'b00: begin
        be_calc    = 4'b0001 << in_result[1:0];
        wdata_calc = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = in_result[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{in_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (cap_lane)
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      2'd3:    rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = cap_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (cap_size)
      2'b00:   load_data = {{24{cap_signed & rd_byte[7]}}, rd_byte};
      2'b01:   load_data = {{16{cap_signed & rd_half[15]}}, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (issue) state_next = S_WAIT;
      S_WAIT: if (ack || timeout_hit) state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      cap_rd          <= '0;
      cap_size        <= '0;
      cap_signed      <= 1'b0;
      cap_lane        <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_be          <= '0;
      wb_valid        <= 1'b0;
      wb_we           <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
      exc_misaligned  <= 1'b0;
      exc_bus_timeout <= 1'b0;
    end else begin
      wb_valid        <= 1'b0;
      exc_misaligned  <= 1'b0;
      exc_bus_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_we    <= in_wb_en;
              wb_rd    <= in_rd;
              wb_data  <= in_result;
            end else if (misaligned) begin
              wb_valid       <= 1'b1;
              wb_we          <= 1'b0;
              exc_misaligned <= 1'b1;
            end else begin
              mem_req    <= 1'b1;
              mem_we     <= in_is_store;
              mem_addr   <= {in_result[31:2], 2'b00};
              mem_be     <= be_calc;
              mem_wdata  <= wdata_calc;
              cap_rd     <= in_rd;
              cap_size   <= in_size;
              cap_signed <= in_signed;
              cap_lane   <= in_result[1:0];
              cnt        <= '0;
            end
          end
        end
        S_WAIT: begin
          if (ack) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_we    <= !mem_we;
            if (!mem_we) begin
              wb_rd   <= cap_rd;
              wb_data <= load_data;
            end
          end else if (timeout_hit) begin
            mem_req         <= 1'b0;
            wb_valid        <= 1'b1;
            wb_we           <= 1'b0;
            exc_bus_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever wb_valid is presented.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_op;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic        in_is_load;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misaligned;
  logic        exc_bus_timeout;

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_op(in_op), .in_result(in_result),
    .in_store_data(in_store_data), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_size(in_size), .in_signed(in_signed), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .stall_out(stall_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_misaligned(exc_misaligned), .exc_bus_timeout(exc_bus_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        cmp_val;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic [4:0] rd, input logic we,
                      input logic cmp_val, input logic mis, input logic to);
    exp_t e;
    e.data = data; e.rd = rd; e.we = we; e.cmp_val = cmp_val; e.mis = mis; e.to = to;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] result, input logic [31:0] sdata,
                        input logic ld, input logic st, input logic [1:0] size,
                        input logic sgn, input logic [4:0] rd, input logic wben);
    in_valid      = 1'b1;
    in_op         = (ld | st) ? 5'd3 : 5'd0;
    in_result     = result;
    in_store_data = sdata;
    in_is_load    = ld;
    in_is_store   = st;
    in_size       = size;
    in_signed     = sgn;
    in_rd         = rd;
    in_wb_en      = wben;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_wb_en    = 1'b0;
  endtask

  // Monitor: every wb_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wb_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wb: got wb_valid=1 expected no retirement at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
          chk("exc_misaligned", {31'd0, exc_misaligned}, {31'd0, e.mis});
          chk("exc_bus_timeout", {31'd0, exc_bus_timeout}, {31'd0, e.to});
          if (e.cmp_val) begin
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
            chk("wb_data", wb_data, e.data);
          end
        end
      end else if (exc_misaligned || exc_bus_timeout) begin
        n_cmp++;
        n_err++;
        $display("FAIL exc_without_wb: got exc=%b%b expected 00", exc_misaligned, exc_bus_timeout);
      end
    end
  end

  task automatic chk_req(input string nm, input logic [31:0] addr, input logic [3:0] be,
                         input logic we);
    chk({nm, "_stall"}, {31'd0, stall_out}, 32'd1);
    chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
    chk({nm, "_addr"}, mem_addr, addr);
    chk({nm, "_be"}, {28'd0, mem_be}, {28'd0, be});
    chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, we});
  endtask

  // Issue an aligned load and ack it on WAIT cycle `lat` (1 = first cycle).
  task automatic load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [4:0] rd, input logic [31:0] rdata,
                      input logic [3:0] be, input logic [31:0] exp, input int lat);
    set_op(addr, 32'h0, 1'b1, 1'b0, size, sgn, rd, 1'b0);
    push(exp, rd, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle_in();
    for (int i = 1; i <= lat; i++) begin
      chk_req(nm, {addr[31:2], 2'b00}, be, 1'b0);
      if (i == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk({nm, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    chk({nm, "_stall_drop"}, {31'd0, stall_out}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    in_op = '0; in_result = '0; in_store_data = '0; in_size = '0; in_signed = 1'b0; in_rd = '0;
    idle_in();
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back non-memory ops retire every cycle
    set_op(32'h12345678, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd5, 1'b1);
    push(32'h12345678, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b0_valid", {31'd0, wb_valid}, 32'd1);
    set_op(32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd7, 1'b0);
    push(32'hCAFEF00D, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b1_valid", {31'd0, wb_valid}, 32'd1);
    set_op(32'h00000001, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1);
    push(32'h00000001, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b2_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_no_stall", {31'd0, stall_out}, 32'd0);
    idle_in();
    tick();
    chk("idle_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Loads: sizing, lane select, sign/zero extension, ack latencies
    load("lb_s", 32'h00001003, 2'b00, 1'b1, 5'd3, 32'h80FF0000, 4'b1000, 32'hFFFFFF80, 3);
    load("lb_u", 32'h00001003, 2'b00, 1'b0, 5'd4, 32'h80FF0000, 4'b1000, 32'h00000080, 1);
    load("lh_s", 32'h00002002, 2'b01, 1'b1, 5'd6, 32'h80011234, 4'b1100, 32'hFFFF8001, 2);
    load("lw",   32'h00003000, 2'b10, 1'b1, 5'd8, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1);

    // Half store with lane replication
    set_op(32'h00002002, 32'hAAAABEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd1, 1'b0);
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    chk_req("sh", 32'h00002000, 4'b1100, 1'b1);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sh_wb_valid", {31'd0, wb_valid}, 32'd1);

    // Byte store; store flag wins over load flag
    set_op(32'h00001001, 32'h123456A5, 1'b1, 1'b1, 2'b00, 1'b0, 5'd1, 1'b0);
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    chk_req("sb", 32'h00001000, 4'b0010, 1'b1);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // Misaligned word and half: no request, exception pulse
    set_op(32'h00003001, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd2, 1'b0);
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("mis_w_req", {31'd0, mem_req}, 32'd0);
    chk("mis_w_stall", {31'd0, stall_out}, 32'd0);
    chk("mis_w_exc", {31'd0, exc_misaligned}, 32'd1);
    set_op(32'h00003001, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 5'd2, 1'b0);
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle_in();
    chk("mis_h_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("mis_clear", {31'd0, exc_misaligned}, 32'd0);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_wb", {31'd0, wb_valid}, 32'd0);

    // Timeout: 4 WAIT cycles without ack, then abort
    set_op(32'h00004000, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 1'b0);
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("to_req_held", {31'd0, mem_req}, 32'd1);
      tick();
    end
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_exc", {31'd0, exc_bus_timeout}, 32'd1);
    chk("to_stall_drop", {31'd0, stall_out}, 32'd0);

    // Ack on the 4th WAIT cycle beats the timeout
    set_op(32'h00004000, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 1'b0);
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("to_ack_req_held", {31'd0, mem_req}, 32'd1);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("to_ack_exc", {31'd0, exc_bus_timeout}, 32'd0);
    chk("to_ack_req_drop", {31'd0, mem_req}, 32'd0);

    // Asynchronous reset mid-WAIT abandons the request
    set_op(32'h00005000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd10, 1'b0);
    tick();
    idle_in();
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_stall", {31'd0, stall_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_wb", {31'd0, wb_valid}, 32'd0);
    chk("post_rst_stall", {31'd0, stall_out}, 32'd0);
    set_op(32'h0000BEEF, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd31, 1'b1);
    push(32'h0000BEEF, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    idle_in();

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();
    chk("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU in the simple Dioptase pipe.
- Consumes the ALU result: effective address for memory ops (op 3..11), final value for all others.
- Runs the data-memory request/ack handshake with byte/half/word sizing, alignment checking and a bus timeout.
- Produces the registered writeback bundle and a stall back to execute while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, default 255: cycles in WAIT without ack before abort; 0 disables the timeout.
- CNT_W, default 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  execute holds a real (non-bubble) instruction
- in_op  in  5  opcode; 3..11 = memory class
- in_result  in  32  ALU result (address or value)
- in_store_data  in  32  store source register value
- in_is_load  in  1  decoded load
- in_is_store  in  1  decoded store
- in_size  in  2  00 byte, 01 half, 10/11 word
- in_signed  in  1  sign-extend sub-word loads
- in_rd  in  5  destination register
- in_wb_en  in  1  non-memory instruction writes rd
- stall_out  out  1  execute must hold its instruction and suppress flag update
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_ack  in  1  request completes on this edge
- mem_rdata  in  32  read data, valid with mem_ack
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_we  out  1  write wb_data to wb_rd
- wb_rd  out  5  destination register
- wb_data  out  32  writeback value
- exc_misaligned  out  1  one-cycle pulse with wb_valid
- exc_bus_timeout  out  1  one-cycle pulse with wb_valid

Behaviour:
- Reset (async, any state, including mid-WAIT):
  - All outputs 0; state IDLE; timeout counter 0.
  - An outstanding request is abandoned; mem_req falls immediately.
- States:
  - IDLE: accept an instruction.
  - WAIT: request outstanding.
- stall_out = (state == WAIT), combinational from state. Execute must hold its inputs stable while stall_out = 1.
- IDLE, in_valid = 0:
  - Next edge: wb_valid = 0; everything else holds.
- IDLE, in_valid, not a memory op (in_is_load = in_is_store = 0):
  - Next edge: wb_valid = 1, wb_data = in_result, wb_rd = in_rd, wb_we = in_wb_en.
  - Latency 1; back-to-back issue every cycle.
- IDLE, in_valid, memory op:
  - in_is_store has precedence if both load and store are set.
  - Misaligned access = half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - Misaligned: no request. Next edge: wb_valid = 1, wb_we = 0, exc_misaligned = 1; stay in IDLE.
  - Aligned: next edge registers mem_req = 1, mem_we, mem_addr, mem_be, mem_wdata and the load controls (rd, size, signed, addr[1:0]); state → WAIT; counter cleared.
- Store data and byte enables:
  - byte: mem_wdata = data[7:0] replicated ×4; mem_be = 4'b0001 << addr[1:0].
  - half: mem_wdata = data[15:0] replicated ×2; mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - word: mem_wdata = data; mem_be = 4'b1111.
  - Loads drive mem_be to the same pattern.
- WAIT:
  - mem_req and all request fields stay stable until an edge where mem_ack = 1.
  - mem_ack is sampled only when mem_req = 1; ack outside WAIT is ignored.
  - Ack is legal on the first WAIT cycle, giving a minimum 2-cycle memory latency.
- On the ack edge:
  - mem_req ← 0; state → IDLE; wb_valid ← 1.
  - Load: wb_we = 1 and wb_rd = captured rd. wb_data = lane selected by addr[1:0] (byte) or addr[1] (half), extended per in_signed; word passes through.
  - Store: wb_we = 0.
- Timeout:
  - The counter increments each WAIT cycle without ack.
  - When counter == TIMEOUT_CYCLES − 1 with no ack: next edge mem_req ← 0, wb_valid = 1, wb_we = 0, exc_bus_timeout = 1, state → IDLE.
  - Ack on the same edge as the timeout: ack wins.
- wb_valid, exc_misaligned and exc_bus_timeout are single-cycle pulses, cleared on the following edge unless re-fired.
- When stall_out drops, the instruction held by execute is accepted in that same IDLE cycle.

Test Plan:
- Reset with rst_n = 0 mid-WAIT → mem_req = 0 and stall_out = 0 immediately; after release wb_valid = 0, state IDLE.
- Non-mem op, in_result = 0x12345678, rd = 5, wb_en = 1 → next cycle wb_valid = 1, wb_we = 1, wb_rd = 5, wb_data = 0x12345678; back-to-back ops retire every cycle.
- Signed byte load, addr 0x1003, ack after 3 cycles with rdata 0x80FF_0000:
  - During WAIT: mem_addr = 0x1000, mem_be = 1000, stall_out = 1 for 3 cycles.
  - On completion: wb_data = 0xFFFFFF80; the unsigned variant gives 0x00000080.
- Half store, addr 0x2002, data 0xAAAA_BEEF → mem_wdata = 0xBEEFBEEF, mem_be = 1100, mem_we = 1; on ack wb_valid = 1, wb_we = 0.
- Word load at addr 0x3001 → no mem_req; next cycle exc_misaligned = 1, wb_we = 0, stall_out never asserted.
- TIMEOUT_CYCLES = 4, store with no ack:
  - mem_req stays high for 4 cycles, then exc_bus_timeout = 1 and mem_req = 0.
  - Repeating with ack on the 4th cycle completes normally with no exception.
